// File: rtl/nibble_link_host.sv
// Host end of the 4-bit nibble link: serialises 32-bit words MSB-nibble first and
// reassembles framed result nibbles. Optional framing check: NIBBLE_LINK_CHECK_EN.
module nibble_link_host #(
  parameter int GAP_CYCLES = 4,
  parameter int NIBBLES    = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_dir_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  tx_nibble,
  output logic        tx_dir_r,
  output logic        tx_frame,
  output logic        tx_busy,
  input  logic [3:0]  rx_nibble,
  input  logic        rx_start,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        rx_error
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
  typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;

  localparam logic [2:0] LAST_NIB = 3'(NIBBLES - 1);
  localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

  tx_state_t   tx_state, tx_next;
  logic [31:0] tx_shift;
  logic [2:0]  nib_cnt;
  logic [3:0]  gap_cnt;
  logic        tx_accept;

  rx_state_t   rx_state, rx_next;
  logic [27:0] rx_shift;
  logic [2:0]  rx_cnt;
  logic        rx_done;

  always_comb begin
    tx_next   = tx_state;
    tx_accept = 1'b0;
    in_ready  = 1'b0;
    tx_busy   = 1'b1;
    tx_nibble = 4'h0;
    tx_frame  = 1'b0;
    case (tx_state)
      IDLE: begin
        in_ready = 1'b1;
        tx_busy  = 1'b0;
        if (in_valid) begin
          tx_accept = 1'b1;
          tx_next   = SEND;
        end
      end
      SEND: begin
        tx_nibble = tx_shift[31:28];
        tx_frame  = (nib_cnt == 3'd0);
        if (nib_cnt == LAST_NIB)
          tx_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt == LAST_GAP)
          tx_next = IDLE;
      end
      default: tx_next = IDLE;
    endcase
  end

  // tx_dir_r is only reloaded on a transfer, so it stays valid through GAP and IDLE
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_shift <= 32'h0;
      tx_dir_r <= 1'b0;
      nib_cnt  <= 3'd0;
      gap_cnt  <= 4'd0;
    end else begin
      tx_state <= tx_next;
      if (tx_accept) begin
        tx_shift <= in_word;
        tx_dir_r <= in_dir_r;
        nib_cnt  <= 3'd0;
      end else if (tx_state == SEND) begin
        tx_shift <= {tx_shift[27:0], 4'h0};
        nib_cnt  <= nib_cnt + 3'd1;
        gap_cnt  <= 4'd0;
      end else if (tx_state == GAP) begin
        gap_cnt <= gap_cnt + 4'd1;
      end
    end
  end

  // rx_cnt holds nibbles already collected; the 8th nibble completes straight into result
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    if (rx_start) begin
      rx_next = RX_COLLECT;
    end else if (rx_state == RX_COLLECT && rx_cnt == LAST_NIB) begin
      rx_next = RX_IDLE;
      rx_done = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rx_state     <= RX_IDLE;
      rx_shift     <= 28'h0;
      rx_cnt       <= 3'd0;
      result       <= 32'h0;
      result_valid <= 1'b0;
    end else begin
      rx_state     <= rx_next;
      result_valid <= rx_done;
      if (rx_start) begin
        rx_shift <= {24'h0, rx_nibble};
        rx_cnt   <= 3'd1;
      end else if (rx_state == RX_COLLECT) begin
        rx_shift <= {rx_shift[23:0], rx_nibble};
        rx_cnt   <= rx_cnt + 3'd1;
      end
      if (rx_done)
        result <= {rx_shift, rx_nibble};
    end
  end

`ifdef NIBBLE_LINK_CHECK_EN
  logic err_q;

  // A start inside a frame, or noise on an idle link, marks the link as suspect
  always_ff @(posedge sys_clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if ((rx_start && rx_state == RX_COLLECT) ||
             (!rx_start && rx_state == RX_IDLE && rx_nibble != 4'h0))
      err_q <= 1'b1;
  end

  assign rx_error = err_q;
`else
  assign rx_error = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_link_host.sv
// Directed + randomized bench for nibble_link_host with a frame-level reference model.
// Honours NIBBLE_LINK_CHECK_EN for the rx_error expectation.
module tb_nibble_link_host;

  localparam int GAP = 4;
  localparam int NIB = 8;

  typedef struct packed {
    logic       s;
    logic [3:0] n;
  } rx_item_t;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [31:0] in_word;
  logic        in_dir_r;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  tx_nibble;
  logic        tx_dir_r;
  logic        tx_frame;
  logic        tx_busy;
  logic [3:0]  rx_nibble;
  logic        rx_start;
  logic [31:0] result;
  logic        result_valid;
  logic        rx_error;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;
  int cycleNum   = 0;
  int acceptCycles[$];

  rx_item_t    rxPlan[$];
  logic [3:0]  nibs[$];
  bit          collecting = 0;
  bit          expValid   = 0;
  bit          errModel   = 0;
  logic [31:0] expResult  = 32'h0;
  logic        lastDir    = 1'b0;

  always #5 sys_clk = ~sys_clk;

  nibble_link_host #(.GAP_CYCLES(GAP), .NIBBLES(NIB)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .in_word(in_word), .in_dir_r(in_dir_r), .in_valid(in_valid), .in_ready(in_ready),
    .tx_nibble(tx_nibble), .tx_dir_r(tx_dir_r), .tx_frame(tx_frame), .tx_busy(tx_busy),
    .rx_nibble(rx_nibble), .rx_start(rx_start),
    .result(result), .result_valid(result_valid), .rx_error(rx_error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] txView();
    return {24'h0, in_ready, tx_busy, tx_frame, tx_dir_r, tx_nibble};
  endfunction

  function automatic logic [31:0] txExp(input logic rdy, input logic busy, input logic frm,
                                        input logic dir, input logic [3:0] nib);
    return {24'h0, rdy, busy, frm, dir, nib};
  endfunction

  // A frame is just the 8 collected nibbles read as a big-endian hex number
  function automatic logic [31:0] assemble();
    logic [31:0] w = 32'h0;
    foreach (nibs[i]) w = w * 16 + 32'(nibs[i]);
    return w;
  endfunction

  task automatic rxModel(input logic s, input logic [3:0] n);
    expValid = 0;
    if (s) begin
      if (collecting) errModel = 1;
      nibs.delete();
      nibs.push_back(n);
      collecting = 1;
    end else if (collecting) begin
      nibs.push_back(n);
    end else if (n != 4'h0) begin
      errModel = 1;
    end
    if (collecting && nibs.size() == NIB) begin
      expResult  = assemble();
      expValid   = 1;
      collecting = 0;
      nibs.delete();
    end
  endtask

  // One clock: feed the next planned RX item, record accepts, check the RX side
  task automatic applyStimulus();
    rx_item_t it;
    bit accepted;
    it = (rxPlan.size() > 0) ? rxPlan.pop_front() : rx_item_t'(5'h0);
    rx_start  = it.s;
    rx_nibble = it.n;
    accepted  = rst && in_valid && in_ready;
    @(posedge sys_clk);
    cycleNum++;
    if (accepted) acceptCycles.push_back(cycleNum);
    @(negedge sys_clk);
    if (!rst) begin
      nibs.delete();
      collecting = 0;
      expValid   = 0;
      errModel   = 0;
      expResult  = 32'h0;
      lastDir    = 1'b0;
    end else begin
      rxModel(it.s, it.n);
    end
    checkOutput("rx_valid", 32'(result_valid), 32'(expValid));
    checkOutput("rx_result", result, expResult);
`ifdef NIBBLE_LINK_CHECK_EN
    checkOutput("rx_error", 32'(rx_error), 32'(errModel));
`else
    checkOutput("rx_error", 32'(rx_error), 32'h0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic queueRx(input logic [31:0] w, input int count);
    for (int i = 0; i < count; i++)
      rxPlan.push_back('{s: (i == 0), n: w[31-4*i -: 4]});
  endtask

  task automatic txFrame(input logic [31:0] w, input logic d, input bit holdNext,
                         input logic [31:0] nw, input logic nd);
    in_word  = w;
    in_dir_r = d;
    in_valid = 1'b1;
    checkOutput("tx_ready", txView(), txExp(1'b1, 1'b0, 1'b0, lastDir, 4'h0));
    applyStimulus();
    if (holdNext) begin
      in_word  = nw;
      in_dir_r = nd;
    end else begin
      in_valid = 1'b0;
      in_word  = $urandom;
      in_dir_r = ~d;
    end
    for (int k = 0; k < NIB; k++) begin
      checkOutput($sformatf("tx_nib%0d", k), txView(),
                  txExp(1'b0, 1'b1, 1'(k == 0), d, 4'((w >> (28 - 4 * k)) & 32'hF)));
      applyStimulus();
    end
    for (int g = 0; g < GAP; g++) begin
      checkOutput($sformatf("tx_gap%0d", g), txView(), txExp(1'b0, 1'b1, 1'b0, d, 4'h0));
      applyStimulus();
    end
    lastDir = d;
    checkOutput("tx_back_idle", txView(), txExp(1'b1, 1'b0, 1'b0, d, 4'h0));
  endtask

  initial begin
    int firstAcc;
    int spacing;
    rst       = 1'b0;
    in_word   = 32'h0;
    in_dir_r  = 1'b0;
    in_valid  = 1'b0;
    rx_nibble = 4'h0;
    rx_start  = 1'b0;
    @(negedge sys_clk);
    idle(2);
    checkOutput("reset_tx", txView(), txExp(1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    rst = 1'b1;
    idle(1);

    $display("[TB] directed transmit 0x12345678");
    txFrame(32'h12345678, 1'b1, 0, 32'h0, 1'b0);
    idle(2);

    $display("[TB] back-to-back transmit");
    firstAcc = acceptCycles.size();
    txFrame(32'h0000000A, 1'b0, 1, 32'hFFFFFFFF, 1'b1);
    txFrame(32'hFFFFFFFF, 1'b1, 0, 32'h0, 1'b0);
    spacing = (acceptCycles.size() >= firstAcc + 2) ?
              acceptCycles[firstAcc + 1] - acceptCycles[firstAcc] : 0;
    checkOutput("b2b_spacing", 32'(spacing), 32'(1 + NIB + GAP));

    $display("[TB] directed receive");
    queueRx(32'h000003E7, 8);
    idle(10);
    queueRx(32'h12340000, 4);
    queueRx(32'hDEADBEEF, 8);
    idle(14);

    $display("[TB] receive alongside transmit");
    queueRx(32'h5A5AC3C3, 8);
    idle(7);
    txFrame(32'h87654321, 1'b1, 0, 32'h0, 1'b0);

    $display("[TB] reset mid-frame");
    queueRx(32'h56789123, 8);
    idle(1);
    in_word  = 32'hCAFEF00D;
    in_dir_r = 1'b1;
    in_valid = 1'b1;
    idle(1);
    in_valid = 1'b0;
    idle(3);
    checkOutput("pre_reset_nib4", txView(), txExp(1'b0, 1'b1, 1'b0, 1'b1, 4'hE));
    rst = 1'b0;
    rxPlan.delete();
    idle(1);
    checkOutput("midreset_tx", txView(), txExp(1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    rst = 1'b1;
    idle(2);
    txFrame(32'h0F1E2D3C, 1'b1, 0, 32'h0, 1'b0);

    $display("[TB] randomized traffic");
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 3) == 0)
        queueRx($urandom, $urandom_range(1, 7));
      queueRx($urandom, 8);
      for (int z = 0; z < int'($urandom_range(0, 3)); z++)
        rxPlan.push_back('{s: 1'b0, n: 4'h0});
      txFrame($urandom, 1'($urandom_range(0, 1)), 0, 32'h0, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(12);
    rxPlan.push_back('{s: 1'b0, n: 4'h9});
    idle(3);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
